// File: rtl/food_spawn_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// snake_pkg : shared types for the snake game food placement logic.
//   pos_t          {x[7:0], y[6:0]} playfield cell, same packing as segment RAM
//   spawn_state_e  food_spawn_ctrl sequencer states
//   on_grid()      unsigned bounds check of a candidate cell
// ----------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_W_DEF = 160;
    localparam int GRID_H_DEF = 120;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } pos_t;

    typedef enum logic [2:0] {IDLE, SAMPLE, SCAN, REJECT, ACCEPT} spawn_state_e;

    // Plain unsigned compare: no wrap or modulo folding of off-grid values.
    function automatic logic on_grid(input pos_t p, input int gw, input int gh);
        return (int'(p.x) < gw) && (int'(p.y) < gh);
    endfunction

endpackage

// File: rtl/food_spawn_ctrl_if.sv
// ----------------------------------------------------------------------------
// food_spawn_ctrl_if : game FSM <-> food spawner handshake.
//   spawn_req   game -> spawner  one-cycle request pulse
//   food_pos    spawner -> game  current food cell
//   food_valid  spawner -> game  food_pos is meaningful
//   busy        spawner -> game  request in progress
//   spawn_done  spawner -> game  one-cycle pulse, food placed
//   spawn_fail  spawner -> game  one-cycle pulse, retries exhausted
//   tries_used  spawner -> game  candidates used by last request (stats build)
// modports: master = game FSM side, slave = spawner side.
// ----------------------------------------------------------------------------
interface food_spawn_ctrl_if
    import snake_pkg::*;
#(
    parameter int TW = 7
);
    logic          spawn_req;
    pos_t          food_pos;
    logic          food_valid;
    logic          busy;
    logic          spawn_done;
    logic          spawn_fail;
    logic [TW-1:0] tries_used;

    modport master (
        output spawn_req,
        input  food_pos, food_valid, busy, spawn_done, spawn_fail, tries_used
    );

    modport slave (
        input  spawn_req,
        output food_pos, food_valid, busy, spawn_done, spawn_fail, tries_used
    );
endinterface

// File: rtl/food_spawn_ctrl_seg_scan.sv
// ----------------------------------------------------------------------------
// food_seg_scan : walks the snake segment RAM and compares each segment with
// the current food candidate.
//   clk, rst      clock, async active-high reset
//   i_start       clear the index (driven during SAMPLE)
//   i_scan        scan in progress; one read address issued per cycle
//   i_len         latched segment count (non-zero while scanning)
//   i_cand        candidate cell
//   i_rd_data     RAM read data, valid one cycle after o_addr
//   o_addr        RAM read address (straight from the index counter)
//   o_hit         read data on the bus matches the candidate
//   o_last        read data on the bus belongs to segment len-1
// ----------------------------------------------------------------------------
module food_seg_scan
    import snake_pkg::*;
#(
    parameter  int MAX_LEN = 256,
    localparam int LW      = $clog2(MAX_LEN + 1),
    localparam int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_scan,
    input  logic [LW-1:0] i_len,
    input  pos_t          i_cand,
    input  pos_t          i_rd_data,
    output logic [AW-1:0] o_addr,
    output logic          o_hit,
    output logic          o_last
);

    logic [AW-1:0] r_idx;
    logic          r_vld;   // an address was issued last cycle
    logic          r_last;  // ... and it was the final segment
    logic          w_more;

    assign w_more = (LW'(r_idx) < (i_len - LW'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end else begin
            if (i_start)
                r_idx <= '0;
            else if (i_scan && w_more)
                r_idx <= r_idx + 1'b1;
            // Flags delayed by one cycle to line up with the RAM's read latency.
            r_vld  <= i_scan;
            r_last <= i_scan && !w_more;
        end
    end

    assign o_addr = r_idx;
    // RAM output is already a register, so comparing it here keeps the scan
    // at len+1 cycles.
    assign o_hit  = r_vld && (i_rd_data == i_cand);
    assign o_last = r_vld && r_last;

endmodule

// File: rtl/food_spawn_ctrl.sv
// ----------------------------------------------------------------------------
// food_spawn_ctrl : places food for the snake game. On request it samples the
// free-running position RNG, rejects off-grid cells, scans the snake body RAM
// for collisions and retries until a free cell is found or MAX_TRIES is hit.
//   clk, rst        clock, async active-high reset
//   i_rng_posX/Y    pos_rng outputs, sampled once per candidate
//   i_snake_len     live segment count, latched per candidate
//   o_seg_rd_addr   segment RAM read address
//   i_seg_rd_data   segment RAM data, one cycle after the address
//   gif (slave)     spawn_req / food_pos / food_valid / busy / done / fail /
//                   tries_used handshake with the game FSM
// Build option: FOOD_SPAWN_STATS_EN enables the tries_used register;
// otherwise tries_used is tied to zero.
// ----------------------------------------------------------------------------
module food_spawn_ctrl
    import snake_pkg::*;
#(
    parameter  int GRID_W    = GRID_W_DEF,
    parameter  int GRID_H    = GRID_H_DEF,
    parameter  int MAX_LEN   = 256,
    parameter  int MAX_TRIES = 64,
    localparam int LW        = $clog2(MAX_LEN + 1),
    localparam int AW        = $clog2(MAX_LEN),
    localparam int TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_rng_posX,
    input  logic [6:0]         i_rng_posY,
    input  logic [LW-1:0]      i_snake_len,
    output logic [AW-1:0]      o_seg_rd_addr,
    input  pos_t               i_seg_rd_data,
    food_spawn_ctrl_if.slave   gif
);

    spawn_state_e  r_state;
    pos_t          r_cand;
    logic [LW-1:0] r_len;
    logic [TW-1:0] r_tries;
    pos_t          r_food_pos;
    logic          r_food_valid;
    logic          r_busy;
    logic          r_done;
    logic          r_fail;

    pos_t          w_rng;
    logic          w_hit;
    logic          w_last;
    logic          w_exhausted;

    assign w_rng       = {i_rng_posX, i_rng_posY};
    assign w_exhausted = (r_tries == TW'(MAX_TRIES));

    food_seg_scan #(.MAX_LEN(MAX_LEN)) u_scan (
        .clk       (clk),
        .rst       (rst),
        .i_start   (r_state == SAMPLE),
        .i_scan    (r_state == SCAN),
        .i_len     (r_len),
        .i_cand    (r_cand),
        .i_rd_data (i_seg_rd_data),
        .o_addr    (o_seg_rd_addr),
        .o_hit     (w_hit),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cand       <= '0;
            r_len        <= '0;
            r_tries      <= '0;
            r_food_pos   <= '0;
            r_food_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (gif.spawn_req) begin
                        r_food_valid <= 1'b0;
                        r_tries      <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_cand  <= w_rng;
                    r_len   <= i_snake_len;
                    r_tries <= r_tries + 1'b1;
                    if (!on_grid(w_rng, GRID_W, GRID_H))
                        r_state <= REJECT;      // never touches the RAM
                    else if (i_snake_len == '0)
                        r_state <= ACCEPT;
                    else
                        r_state <= SCAN;
                end
                SCAN: begin
                    if (w_hit)
                        r_state <= REJECT;      // drop the remaining reads
                    else if (w_last)
                        r_state <= ACCEPT;
                end
                REJECT: begin
                    if (w_exhausted) begin
                        r_fail  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= SAMPLE;
                    end
                end
                ACCEPT: begin
                    r_food_pos   <= r_cand;
                    r_food_valid <= 1'b1;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gif.food_pos   = r_food_pos;
    assign gif.food_valid = r_food_valid;
    assign gif.busy       = r_busy;
    assign gif.spawn_done = r_done;
    assign gif.spawn_fail = r_fail;

`ifdef FOOD_SPAWN_STATS_EN
    logic [TW-1:0] r_tries_used;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tries_used <= '0;
        else if ((r_state == ACCEPT) || ((r_state == REJECT) && w_exhausted))
            r_tries_used <= r_tries;
    end

    assign gif.tries_used = r_tries_used;
`else
    assign gif.tries_used = '0;
`endif

endmodule
